des_key_scheduler: RTL and testbench

DES_KEY_SCHEDULER -- requirements
Module: des_key_scheduler

---
 rtl/des_pkg.sv | 42 ++++
 rtl/des_pc1.sv | 23 ++
 rtl/des_pc2.sv | 23 ++
 rtl/des_key_scheduler.sv | 155 +++++++++++++++
 tb/tb_des_key_scheduler.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/des_pkg.sv
// des_pkg: shared definitions for the DES key scheduler.
//   state_e   : scheduler FSM states
//   SHIFT_TBL : per-round left-rotation amounts s1..s16 (index 0 = s1)
//   PC1_TBL   : permuted choice 1, 64 -> 56 bits (bit position 1 = MSB)
//   PC2_TBL   : permuted choice 2, 56 -> 48 bits (bit position 1 = MSB)
//   rotl28 / rotr28 : 28-bit rotations by 1 or 2
package des_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_EMIT   = 2'd1,
    ST_FINISH = 2'd2
  } state_e;

  localparam logic [1:0] SHIFT_TBL [16] = '{
    2'd1, 2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2,
    2'd1, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd2, 2'd1
  };

  localparam int PC1_TBL [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  localparam int PC2_TBL [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [27:0] rotl28(input logic [27:0] x, input logic [1:0] s);
    return (s == 2'd2) ? {x[25:0], x[27:26]} : {x[26:0], x[27]};
  endfunction

  function automatic logic [27:0] rotr28(input logic [27:0] x, input logic [1:0] s);
    return (s == 2'd2) ? {x[1:0], x[27:2]} : {x[0], x[27:1]};
  endfunction

endpackage

// File: rtl/des_pc1.sv
// des_pc1: DES permuted choice 1 (combinational).
//   key_in  [63:0] : raw key, bit position 1 = key_in[63]; parity bits dropped
//   pc1_out [55:0] : {C0, D0}
module des_pc1
  import des_pkg::*;
(
  input  logic [63:0] key_in,
  output logic [55:0] pc1_out
);

  // Every eighth key bit is parity and never selected by the table.
  logic unused_parity;
  assign unused_parity = ^{key_in[56], key_in[48], key_in[40], key_in[32],
                           key_in[24], key_in[16], key_in[8],  key_in[0]};

  always_comb begin
    pc1_out = '0;
    for (int k = 0; k < 56; k++) begin
      pc1_out[55-k] = key_in[64-PC1_TBL[k]];
    end
  end

endmodule

// File: rtl/des_pc2.sv
// des_pc2: DES permuted choice 2 (combinational).
//   cd_in  [55:0] : {C, D}, bit position 1 = cd_in[55]
//   subkey [47:0] : round subkey, table index 1 lands in subkey[47]
module des_pc2
  import des_pkg::*;
(
  input  logic [55:0] cd_in,
  output logic [47:0] subkey
);

  // Eight C/D positions are not part of any subkey.
  logic unused_cd;
  assign unused_cd = ^{cd_in[47], cd_in[38], cd_in[34], cd_in[31],
                       cd_in[21], cd_in[18], cd_in[13], cd_in[2]};

  always_comb begin
    subkey = '0;
    for (int k = 0; k < 48; k++) begin
      subkey[47-k] = cd_in[56-PC2_TBL[k]];
    end
  end

endmodule

// File: rtl/des_key_scheduler.sv
// des_key_scheduler: produces the 16 DES round subkeys over a valid/ready
// stream, in encrypt order (K1..K16) or decrypt order (K16..K1).
//   clk, rst_n            : clock, async active-low reset
//   key_in, start, decrypt: schedule request, sampled only when accepted in IDLE
//   abort                 : cancel a running schedule
//   subkey_ready          : consumer accepts the presented subkey
//   busy                  : not in IDLE
//   subkey, subkey_valid  : presented subkey (PC2 of C/D) and its valid flag
//   round_idx             : round number minus 1 of the presented subkey
//   done                  : one-cycle pulse after the last subkey transfers
//
// state     | meaning
// ----------+---------------------------------------------------
// ST_IDLE   | waiting for start, outputs quiet
// ST_EMIT   | subkey_valid high, advancing C/D on each handshake
// ST_FINISH | last subkey transferred, done high for this cycle
module des_key_scheduler
  import des_pkg::*;
#(
  parameter int NUM_ROUNDS = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [63:0] key_in,
  input  logic        start,
  input  logic        decrypt,
  input  logic        abort,
  input  logic        subkey_ready,
  output logic        busy,
  output logic [47:0] subkey,
  output logic        subkey_valid,
  output logic [3:0]  round_idx,
  output logic        done
);

  localparam logic [3:0] LAST_IDX = 4'(NUM_ROUNDS - 1);

  state_e      state_q, state_d;
  logic [27:0] c_q, c_d, d_q, d_d;
  logic [3:0]  round_idx_q, round_idx_d;
  logic        dec_q, dec_d;
  logic        busy_q, busy_d;
  logic        valid_q, valid_d;
  logic        done_q, done_d;

  logic [55:0] pc1_out;
  logic [47:0] pc2_out;
  logic [3:0]  idx_next;
  logic [1:0]  shift_enc, shift_dec;
  logic        handshake, last_round;

  des_pc1 u_pc1 (
    .key_in  (key_in),
    .pc1_out (pc1_out)
  );

  des_pc2 u_pc2 (
    .cd_in  ({c_q, d_q}),
    .subkey (pc2_out)
  );

  assign idx_next   = round_idx_q + 4'd1;
  // Encrypt moves forward to the next round's shift; decrypt undoes the
  // shift that produced the round currently presented.
  assign shift_enc  = SHIFT_TBL[idx_next];
  assign shift_dec  = SHIFT_TBL[round_idx_q];
  assign handshake  = valid_q && subkey_ready;
  assign last_round = dec_q ? (round_idx_q == 4'd0) : (round_idx_q == LAST_IDX);

  always_comb begin
    state_d     = state_q;
    c_d         = c_q;
    d_d         = d_q;
    round_idx_d = round_idx_q;
    dec_d       = dec_q;
    busy_d      = busy_q;
    valid_d     = valid_q;
    done_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (start && !abort) begin
          // C16/D16 equal C0/D0, so decrypt starts unshifted at K16.
          c_d         = decrypt ? pc1_out[55:28] : rotl28(pc1_out[55:28], 2'd1);
          d_d         = decrypt ? pc1_out[27:0]  : rotl28(pc1_out[27:0], 2'd1);
          dec_d       = decrypt;
          round_idx_d = decrypt ? LAST_IDX : 4'd0;
          state_d     = ST_EMIT;
          busy_d      = 1'b1;
          valid_d     = 1'b1;
        end
      end
      ST_EMIT: begin
        if (abort) begin
          state_d = ST_IDLE;
          busy_d  = 1'b0;
          valid_d = 1'b0;
        end else if (handshake) begin
          if (last_round) begin
            state_d = ST_FINISH;
            valid_d = 1'b0;
            done_d  = 1'b1;
          end else if (dec_q) begin
            c_d         = rotr28(c_q, shift_dec);
            d_d         = rotr28(d_q, shift_dec);
            round_idx_d = round_idx_q - 4'd1;
          end else begin
            c_d         = rotl28(c_q, shift_enc);
            d_d         = rotl28(d_q, shift_enc);
            round_idx_d = idx_next;
          end
        end
      end
      ST_FINISH: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
        valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      c_q         <= '0;
      d_q         <= '0;
      round_idx_q <= '0;
      dec_q       <= 1'b0;
      busy_q      <= 1'b0;
      valid_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      c_q         <= c_d;
      d_q         <= d_d;
      round_idx_q <= round_idx_d;
      dec_q       <= dec_d;
      busy_q      <= busy_d;
      valid_q     <= valid_d;
      done_q      <= done_d;
    end
  end

  assign busy         = busy_q;
  assign subkey       = pc2_out;
  assign subkey_valid = valid_q;
  assign round_idx    = round_idx_q;
  assign done         = done_q;

endmodule

// File: tb/tb_des_key_scheduler.sv
// Self-checking bench for des_key_scheduler. Expected subkeys come from a
// table-driven DES key schedule model using cumulative rotations.
module tb_des_key_scheduler;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [63:0] key_in = '0;
  logic        start = 1'b0;
  logic        decrypt = 1'b0;
  logic        abort = 1'b0;
  logic        subkey_ready = 1'b0;
  logic        busy;
  logic [47:0] subkey;
  logic        subkey_valid;
  logic [3:0]  round_idx;
  logic        done;

  int errors = 0;
  int checks = 0;

  int pc1_t [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };
  int pc2_t [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };
  int sh_t [16] = '{1, 1, 2, 2, 2, 2, 2, 2, 1, 2, 2, 2, 2, 2, 2, 1};

  logic [47:0] exp_ks [16];
  logic [47:0] obs_first, obs_last;

  des_key_scheduler #(.NUM_ROUNDS(16)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .key_in       (key_in),
    .start        (start),
    .decrypt      (decrypt),
    .abort        (abort),
    .subkey_ready (subkey_ready),
    .busy         (busy),
    .subkey       (subkey),
    .subkey_valid (subkey_valid),
    .round_idx    (round_idx),
    .done         (done)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed no finish, expected finish before time limit");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // K(r) = PC2(rotl(C0, sum s1..sr), rotl(D0, sum s1..sr)), index r-1.
  task automatic build_model(input logic [63:0] key);
    logic [27:0] c0, d0, cr, dr;
    logic [55:0] cc, dd, cd;
    int tot;
    for (int i = 0; i < 28; i++) begin
      c0[27-i] = key[64-pc1_t[i]];
      d0[27-i] = key[64-pc1_t[i+28]];
    end
    cc  = {c0, c0};
    dd  = {d0, d0};
    tot = 0;
    for (int r = 0; r < 16; r++) begin
      tot = tot + sh_t[r];
      cr  = cc[(55-tot) -: 28];
      dr  = dd[(55-tot) -: 28];
      cd  = {cr, dr};
      for (int k = 0; k < 48; k++) exp_ks[r][47-k] = cd[56-pc2_t[k]];
    end
  endtask

  // mode: 0 = always ready, 1 = random ready, 2 = 5-cycle stall at round 3.
  // abort_at: emission number at which abort is raised with ready, -1 = never.
  task automatic run_sched(input logic [63:0] key, input logic dec, input int mode,
                           input int abort_at, input logic start_in_finish);
    int   emitted, cycles, eidx, stall_cnt;
    logic rdy, ab;
    build_model(key);
    key_in = key; decrypt = dec; start = 1'b1; abort = 1'b0; subkey_ready = 1'b0;
    @(negedge clk);
    start = 1'b0; key_in = {$urandom, $urandom}; decrypt = 1'($urandom_range(0, 1));
    emitted = 0; cycles = 0; stall_cnt = 0;
    while (emitted < 16 && cycles < 400) begin
      cycles++;
      eidx = dec ? 15 - emitted : emitted;
      chk("valid", subkey_valid, 1);
      chk("busy", busy, 1);
      chk("done_early", done, 0);
      chk("subkey", subkey, exp_ks[eidx]);
      chk("round_idx", round_idx, eidx);
      if (emitted == 0)  obs_first = subkey;
      if (emitted == 15) obs_last = subkey;
      if (mode == 0) rdy = 1'b1;
      else if (mode == 1) rdy = 1'($urandom_range(0, 1));
      else if (eidx == 3 && stall_cnt < 5) begin rdy = 1'b0; stall_cnt++; end
      else rdy = 1'b1;
      ab = (emitted == abort_at);
      if (ab) rdy = 1'b1;
      subkey_ready = rdy; abort = ab;
      start = 1'($urandom_range(0, 1)); key_in = {$urandom, $urandom};
      decrypt = 1'($urandom_range(0, 1));
      @(negedge clk);
      abort = 1'b0; start = 1'b0; subkey_ready = 1'b0;
      if (ab) begin
        chk("abort_valid", subkey_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        @(negedge clk);
        chk("abort_no_done", done, 0);
        chk("abort_idle", busy, 0);
        return;
      end
      if (rdy) emitted++;
    end
    chk("emitted_count", emitted, 16);
    chk("finish_done", done, 1);
    chk("finish_valid", subkey_valid, 0);
    chk("finish_busy", busy, 1);
    if (start_in_finish) begin
      start = 1'b1; key_in = {$urandom, $urandom}; decrypt = 1'b0;
    end
    @(negedge clk);
    start = 1'b0;
    chk("post_done", done, 0);
    chk("post_busy", busy, 0);
    chk("post_valid", subkey_valid, 0);
  endtask

  initial begin
    logic [63:0] rkey;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_valid", subkey_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_round_idx", round_idx, 0);
    chk("rst_subkey", subkey, 0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_busy", busy, 0);

    // Zero key, start in FINISH ignored, then all-ones key restarting next cycle.
    run_sched(64'h0, 1'b0, 0, -1, 1'b1);
    chk("zero_first", obs_first, 48'h0);
    run_sched(64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 0, -1, 1'b0);
    chk("ones_first", obs_first, 48'hFFFF_FFFF_FFFF);
    chk("ones_last", obs_last, 48'hFFFF_FFFF_FFFF);

    // Classic worked-example key.
    run_sched(64'h1334_5779_9BBC_DFF1, 1'b0, 0, -1, 1'b0);
    chk("known_k1", obs_first, 48'h1B02_EFFC_7072);
    chk("known_k16", obs_last, 48'hCB3D_8B0E_17F5);
    run_sched(64'h1334_5779_9BBC_DFF1, 1'b1, 0, -1, 1'b0);
    chk("known_dec_first", obs_first, 48'hCB3D_8B0E_17F5);
    chk("known_dec_last", obs_last, 48'h1B02_EFFC_7072);

    // Random key, encrypt then decrypt, with random back-pressure.
    rkey = {$urandom, $urandom};
    run_sched(rkey, 1'b0, 1, -1, 1'b0);
    run_sched(rkey, 1'b1, 1, -1, 1'b0);

    // Stall at round 3 in both directions.
    run_sched({$urandom, $urandom}, 1'b0, 2, -1, 1'b0);
    run_sched({$urandom, $urandom}, 1'b1, 2, -1, 1'b0);

    // Abort at round 7 with ready, then an immediate fresh schedule.
    run_sched({$urandom, $urandom}, 1'b0, 0, 7, 1'b0);
    run_sched({$urandom, $urandom}, 1'b1, 1, -1, 1'b0);

    // Abort beats start in IDLE.
    start = 1'b1; abort = 1'b1; key_in = {$urandom, $urandom};
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    chk("idle_abort_busy", busy, 0);
    chk("idle_abort_valid", subkey_valid, 0);
    @(negedge clk);
    chk("idle_abort_still_idle", busy, 0);

    // Asynchronous reset mid-EMIT.
    key_in = {$urandom, $urandom}; decrypt = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0; subkey_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("pre_rst_busy", busy, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("async_rst_busy", busy, 0);
    chk("async_rst_valid", subkey_valid, 0);
    chk("async_rst_done", done, 0);
    chk("async_rst_round_idx", round_idx, 0);
    chk("async_rst_subkey", subkey, 0);
    @(negedge clk);
    subkey_ready = 1'b0;
    rst_n = 1'b1;
    repeat (2) begin
      @(negedge clk);
      chk("post_rst_done", done, 0);
      chk("post_rst_busy", busy, 0);
    end

    // A few more random schedules.
    for (int n = 0; n < 4; n++) begin
      run_sched({$urandom, $urandom}, 1'($urandom_range(0, 1)), 1, -1, 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
